// File: rtl/rr_arbiter_8way_pkg.sv
// Shared arbiter definitions: requester count, index width, state encoding
// and the default hold limit used by the forced-rotation option.
package rr_arbiter_8way_pkg;
   localparam int N_REQ        = 8;
   localparam int ID_W         = 3;
   localparam int MAX_HOLD_DEF = 15;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arbState_t;

   function automatic logic [N_REQ-1:0] idToOneHot(input logic [ID_W-1:0] id);
      idToOneHot     = '0;
      idToOneHot[id] = 1'b1;
   endfunction
endpackage

// File: rtl/or_8way_gate.sv
// Eight-input OR reduction used for the request and grant summaries.
module or_8way_gate (
   input  logic [7:0] a,
   output logic       y
);
   assign y = |a;
endmodule

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after ptr, mod N_REQ.
module rr_priority_pick
   import rr_arbiter_8way_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  pickId,
   output logic             pickVld
);
   logic [N_REQ-1:0] rot;
   logic [ID_W-1:0]  off;

   // Rotate so ptr lands at bit 0, then a plain lowest-set-bit search.
   assign rot = N_REQ'({req, req} >> ptr);

   always_comb begin
      off = '0;
      for (int i = N_REQ-1; i >= 0; i--)
         if (rot[i]) off = ID_W'(i);
   end

   assign pickId  = ptr + off;
   assign pickVld = |req;
endmodule

// File: rtl/rr_arbiter_8way.sv
// Eight-way round-robin arbiter with registered one-hot grant held while requested.
// Optional forced rotation after MAX_HOLD cycles: define RR_ARBITER_8WAY_TIMEOUT_EN.
module rr_arbiter_8way
   import rr_arbiter_8way_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             busy,
   output logic             any_req,
   output logic             timeout
);
   if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : gBadHold
      $error("MAX_HOLD must lie in 2..15");
   end

   arbState_t        state;
   logic [ID_W-1:0]  ptr;
   logic [N_REQ-1:0] pickReq;
   logic [ID_W-1:0]  pickPtr;
   logic [ID_W-1:0]  pickId;
   logic             pickVld;
   logic             forceRot;
   logic             leaveGrant;

   or_8way_gate uAnyReq (.a(req),   .y(any_req));
   or_8way_gate uBusy   (.a(grant), .y(busy));

   // While granted, search from the slot after the holder with the holder masked,
   // which covers both a normal release and a forced rotation.
   assign pickReq = (state == ARB_GRANT) ? (req & ~grant) : req;
   assign pickPtr = (state == ARB_GRANT) ? (grant_id + ID_W'(1)) : ptr;

   rr_priority_pick uPick (
      .req     (pickReq),
      .ptr     (pickPtr),
      .pickId  (pickId),
      .pickVld (pickVld)
   );

`ifdef RR_ARBITER_8WAY_TIMEOUT_EN
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
   logic [3:0] holdCnt;
   logic       newGrant;

   assign forceRot = (state == ARB_GRANT) && req[grant_id] && (holdCnt == HOLD_LAST) && pickVld;
   assign newGrant = pickVld && ((state == ARB_IDLE) || leaveGrant);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         holdCnt <= '0;
      else if (newGrant)
         holdCnt <= '0;
      else if (state == ARB_GRANT && holdCnt != HOLD_LAST)
         holdCnt <= holdCnt + 4'd1;
   end
`else
   assign forceRot = 1'b0;
`endif

   assign leaveGrant = (state == ARB_GRANT) && (!req[grant_id] || forceRot);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ARB_IDLE;
         grant    <= '0;
         grant_id <= '0;
         ptr      <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (pickVld) begin
                  state    <= ARB_GRANT;
                  grant    <= idToOneHot(pickId);
                  grant_id <= pickId;
               end
            end
            ARB_GRANT: begin
               if (leaveGrant) begin
                  ptr     <= grant_id + ID_W'(1);
                  timeout <= forceRot;
                  if (pickVld) begin
                     grant    <= idToOneHot(pickId);
                     grant_id <= pickId;
                  end else begin
                     state <= ARB_IDLE;
                     grant <= '0;
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rr_arbiter_8way.sv
// Scoreboard bench for rr_arbiter_8way: a cycle model queues the expected
// grant state per edge, popped and compared once the DUT has registered it.
module tb_rr_arbiter_8way;
   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       busy, any_req, timeout;

   always #5 clk = ~clk;

   rr_arbiter_8way #(.MAX_HOLD(MAXH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .any_req  (any_req),
      .timeout  (timeout)
   );

   typedef struct packed {
      logic [7:0] grant;
      logic [2:0] id;
      logic       busy;
      logic       tmo;
   } exp_t;

   exp_t sbQ[$];
   int   nTests = 0;
   int   nFail  = 0;
   int   tmoCount = 0;

   int   mId, mPtr, mCnt;
   logic mBusy, mTmo;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int search(input logic [7:0] r, input int from);
      for (int k = 0; k < 8; k++)
         if (r[(from + k) % 8]) return (from + k) % 8;
      return -1;
   endfunction

   task automatic modelReset();
      mBusy = 1'b0; mId = 0; mPtr = 0; mCnt = 0; mTmo = 1'b0;
      sbQ.delete();
   endtask

   task automatic modelStep(input logic [7:0] r);
      int w;
      mTmo = 1'b0;
      if (!mBusy) begin
         w = search(r, mPtr);
         if (w >= 0) begin mBusy = 1'b1; mId = w; mCnt = 0; end
      end else if (!r[mId]) begin
         mPtr = (mId + 1) % 8;
         w = search(r, mPtr);
         if (w >= 0) begin mId = w; mCnt = 0; end
         else mBusy = 1'b0;
      end else begin
`ifdef RR_ARBITER_8WAY_TIMEOUT_EN
         logic [7:0] others;
         others = r;
         others[mId] = 1'b0;
         if (mCnt == MAXH - 1 && others != 8'h00) begin
            mPtr = (mId + 1) % 8;
            mId  = search(others, mPtr);
            mCnt = 0;
            mTmo = 1'b1;
         end else if (mCnt < MAXH - 1) begin
            mCnt++;
         end
`endif
      end
   endtask

   // Called in the low phase of clk; returns in the next low phase.
   task automatic step(input logic [7:0] r);
      exp_t e;
      req = r;
      #1;
      chk("anyReq", 32'(any_req), 32'(|r));
      modelStep(r);
      e.grant = mBusy ? (8'h01 << mId) : 8'h00;
      e.id    = 3'(mId);
      e.busy  = mBusy;
      e.tmo   = mTmo;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      chk("grant",   32'(grant),   32'(e.grant));
      chk("busy",    32'(busy),    32'(e.busy));
      chk("timeout", 32'(timeout), 32'(e.tmo));
      chk("onehot0", 32'($onehot0(grant)), 32'd1);
      if (e.busy) chk("grantId", 32'(grant_id), 32'(e.id));
      if (timeout) tmoCount++;
      @(negedge clk);
   endtask

   task automatic doReset();
      #2 reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      modelReset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] r;
      reset_n = 1'b0;
      req     = 8'hFF;
      modelReset();
      repeat (3) @(negedge clk);
      #1;
      chk("rstGrant",   32'(grant),   32'h00);
      chk("rstBusy",    32'(busy),    32'd0);
      chk("rstAnyReq",  32'(any_req), 32'd1);
      chk("rstTimeout", 32'(timeout), 32'd0);
      reset_n = 1'b1;
      step(8'hFF);
      chk("firstGrant", 32'(grant), 32'h01);

      // rotation: each holder keeps its grant 3 cycles, drops one cycle, re-raises
      for (int g = 0; g < 8; g++) begin
         step(8'hFF);
         step(8'hFF);
         r = 8'hFF;
         r[grant_id] = 1'b0;
         step(r);
         chk("rotOrder", 32'(grant_id), 32'((g + 1) % 8));
      end

      // wrap 7 -> 0 with a direct switch
      step(8'h80);
      chk("wrapOn7", 32'(grant), 32'h80);
      step(8'h81);
      step(8'h01);
      chk("wrapTo0", 32'(grant), 32'h01);

      // asynchronous reset in the middle of a grant on 5
      step(8'h20);
      step(8'h20);
      chk("grantOn5", 32'(grant), 32'h20);
      #2 reset_n = 1'b0;
      #1;
      chk("asyncGrant", 32'(grant),    32'h00);
      chk("asyncBusy",  32'(busy),     32'd0);
      chk("asyncId",    32'(grant_id), 32'd0);
      req = 8'h24;
      @(posedge clk);
      #1;
      chk("inRstGrant", 32'(grant), 32'h00);
      @(negedge clk);
      reset_n = 1'b1;
      modelReset();
      step(8'h24);
      chk("postRstId", 32'(grant_id), 32'd2);

      // forced rotation (or indefinite hold without the option)
      doReset();
      tmoCount = 0;
      for (int c = 1; c <= 50; c++) begin
         step(8'h03);
`ifdef RR_ARBITER_8WAY_TIMEOUT_EN
         if (c == 4) chk("tmoHold4", 32'(grant), 32'h01);
         if (c == 5) chk("tmoRot",   32'({timeout, grant}), 32'h102);
         if (c == 9) chk("tmoBack",  32'({timeout, grant}), 32'h101);
`else
         if (c == 5)  chk("noTmoHold5",  32'(grant), 32'h01);
         if (c == 50) chk("noTmoHold50", 32'(grant), 32'h01);
`endif
      end
`ifdef RR_ARBITER_8WAY_TIMEOUT_EN
      chk("tmoCount", 32'(tmoCount), 32'd12);
`else
      chk("tmoCount", 32'(tmoCount), 32'd0);
`endif

      // lone requester: no rotation target, so no pulse
      tmoCount = 0;
      repeat (20) step(8'h01);
      chk("loneTmo",   32'(tmoCount), 32'd0);
      chk("loneGrant", 32'(grant),    32'h01);

      step(8'h00);
      chk("idleGrant", 32'(grant), 32'h00);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
